// File: rtl/audiodac_pkg.sv
// Shared constants and types for the audio DAC sigma-delta path.
// Oversampling codes, loop widths and sample-format constants.
package audiodac_pkg;

  localparam int          ACC_W_DEF = 20;
  localparam int          FB_MAG    = 32768;
  localparam logic [15:0] XOR_MASK  = 16'h8000;

  typedef enum logic [1:0] {
    OSR_32  = 2'd0,
    OSR_64  = 2'd1,
    OSR_128 = 2'd2,
    OSR_256 = 2'd3
  } osr_e;

  typedef enum logic {
    MODE_1ST = 1'b0,
    MODE_2ND = 1'b1
  } mode_e;

  // Last counter value of a period, i.e. OSR-1.
  function automatic logic [7:0] osr_last(input logic [1:0] code);
    logic [7:0] r;
    case (osr_e'(code))
      OSR_32:  r = 8'd31;
      OSR_64:  r = 8'd63;
      OSR_128: r = 8'd127;
      OSR_256: r = 8'd255;
      default: r = 8'd31;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/audiodac_sat_integ.sv
// Saturating two's-complement accumulator with async reset, sync clear and enable.
// nxt_o exposes the clamped next value so the quantizer can act on it in the same cycle.
module audiodac_sat_integ
  import audiodac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [ACC_W:0]   add_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic signed [ACC_W-1:0] nxt_o
);

  localparam logic signed [ACC_W+1:0] SAT_HI = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] SAT_LO = {3'b111, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W+1:0] sum;

  // Two guard bits so the clamp sees the true sum before truncation.
  always_comb begin
    sum = {{2{acc_o[ACC_W-1]}}, acc_o} + {add_i[ACC_W], add_i};
    if (sum > SAT_HI)      nxt_o = SAT_HI[ACC_W-1:0];
    else if (sum < SAT_LO) nxt_o = SAT_LO[ACC_W-1:0];
    else                   nxt_o = sum[ACC_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   acc_o <= '0;
    else if (clr_i) acc_o <= '0;
    else if (en_i)  acc_o <= nxt_o;
  end

endmodule

// File: rtl/audiodac_dsmod.sv
// 1st/2nd-order sigma-delta modulator: pulls one offset-binary sample per
// oversampling period, scales it, and emits a differential 1-bit stream.
module audiodac_dsmod
  import audiodac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] data_i,
  output logic        data_rd_o,
  input  logic        mod_en_i,
  input  logic        mode_i,
  input  logic [1:0]  osr_i,
  input  logic [3:0]  volume_i,
  output logic        ds_o,
  output logic        ds_n_o
);

  localparam logic signed [ACC_W:0] FB_P = (ACC_W+1)'(FB_MAG);
  localparam logic signed [ACC_W:0] FB_N = -FB_P;

  logic [7:0]              cnt;
  logic [7:0]              cnt_last;
  logic signed [15:0]      x;
  logic signed [15:0]      x_d;
  logic                    ds;
  logic signed [ACC_W:0]   fb;
  logic signed [ACC_W:0]   add1;
  logic signed [ACC_W:0]   add2;
  logic signed [ACC_W-1:0] a1;
  logic signed [ACC_W-1:0] a2;
  logic signed [ACC_W-1:0] a1_nxt;
  logic signed [ACC_W-1:0] a2_nxt;
  logic                    second;

  // >= rather than == so a shrinking OSR cannot strand cnt above the wrap point.
  assign cnt_last  = osr_last(osr_i);
  assign data_rd_o = mod_en_i && (cnt >= cnt_last);
  assign second    = (mode_e'(mode_i) == MODE_2ND);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       cnt <= '0;
    else if (!mod_en_i) cnt <= '0;
    else if (data_rd_o) cnt <= '0;
    else                cnt <= cnt + 8'd1;
  end

  assign x_d = $signed(data_i ^ XOR_MASK) >>> volume_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       x <= '0;
    else if (data_rd_o) x <= x_d;
  end

  assign fb   = ds ? FB_P : FB_N;
  assign add1 = {{(ACC_W-15){x[15]}}, x} - fb;
  assign add2 = {a1[ACC_W-1], a1} - fb;

  audiodac_sat_integ #(.ACC_W(ACC_W)) u_a1 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (!mod_en_i),
    .en_i    (mod_en_i),
    .add_i   (add1),
    .acc_o   (a1),
    .nxt_o   (a1_nxt)
  );

  // a2 is held at zero whenever the loop runs first-order.
  audiodac_sat_integ #(.ACC_W(ACC_W)) u_a2 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (!mod_en_i || !second),
    .en_i    (mod_en_i),
    .add_i   (add2),
    .acc_o   (a2),
    .nxt_o   (a2_nxt)
  );

  // Idle toggling keeps the output stage at mid-scale while disabled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       ds <= 1'b0;
    else if (!mod_en_i) ds <= ~ds;
    else if (second)    ds <= ~a2_nxt[ACC_W-1];
    else                ds <= ~a1_nxt[ACC_W-1];
  end

  assign ds_o   = ds;
  assign ds_n_o = ~ds;

endmodule
